// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel, WIDTH-bit registered multiplexer with clock enable
// and a round-robin auto-scan mode that skips channels without valid data.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous reset, active-high (overrides en and mode)
//   d        - flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   d_valid  - per-channel valid flags
//   sel      - manual channel select (mode=0)
//   mode     - 0 = manual select, 1 = auto-scan
//   en       - clock enable; all state holds when low
//   z        - registered selected data
//   z_valid  - registered valid of the selected channel
//   z_sel    - registered index of the channel driving z
module mux_scan_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned HOLD  = 1,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   d,
   input  logic [N-1:0]         d_valid,
   input  logic [SELW-1:0]      sel,
   input  logic                 mode,
   input  logic                 en,
   output logic [WIDTH-1:0]     z,
   output logic                 z_valid,
   output logic [SELW-1:0]      z_sel
);

   localparam int unsigned CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;

   logic [WIDTH-1:0] z_q, z_d;
   logic             z_valid_q, z_valid_d;
   logic [SELW-1:0]  z_sel_q, z_sel_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic [WIDTH-1:0] d_ch [N];

   // Unflatten channel data
   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign d_ch[g] = d[g*WIDTH +: WIDTH];
   end

   // Channel lookups for manual select and scan pointer
   logic [WIDTH-1:0] sel_data, ptr_data;
   logic             sel_valid, ptr_valid, sel_in_range;

   always_comb begin
      sel_data     = '0;
      sel_valid    = 1'b0;
      sel_in_range = 1'b0;
      ptr_data     = '0;
      ptr_valid    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == SELW'(i)) begin
            sel_data     = d_ch[i];
            sel_valid    = d_valid[i];
            sel_in_range = 1'b1;
         end
         if (ptr_q == SELW'(i)) begin
            ptr_data  = d_ch[i];
            ptr_valid = d_valid[i];
         end
      end
   end

   // Next valid channel searching ptr+1 .. ptr+N-1, then ptr itself;
   // falls back to ptr+1 when nothing is valid.
   logic [SELW-1:0] scan_next;
   logic            found;

   always_comb begin
      int unsigned idx;
      found     = 1'b0;
      idx       = 32'(ptr_q) + 32'd1;
      if (idx >= N) idx = idx - N;
      scan_next = SELW'(idx);
      for (int unsigned s = 1; s <= N; s++) begin
         idx = 32'(ptr_q) + s;
         if (idx >= N) idx = idx - N;
         if (!found && d_valid[idx]) begin
            found     = 1'b1;
            scan_next = SELW'(idx);
         end
      end
   end

   // Next-state logic; defaults hold every register
   always_comb begin
      z_d       = z_q;
      z_valid_d = z_valid_q;
      z_sel_d   = z_sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      if (en) begin
         if (!mode) begin
            z_sel_d = sel;
            cnt_d   = '0;
            if (sel_in_range) begin
               z_d       = sel_data;
               z_valid_d = sel_valid;
               ptr_d     = sel;
            end else begin
               z_d       = '0;
               z_valid_d = 1'b0;
            end
         end else begin
            z_d       = ptr_data;
            z_valid_d = ptr_valid;
            z_sel_d   = ptr_q;
            // An invalid current channel is shown once, then skipped
            if (!ptr_valid || (cnt_q == CNTW'(HOLD - 1))) begin
               ptr_d = scan_next;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_q       <= '0;
         z_valid_q <= 1'b0;
         z_sel_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
      end else begin
         z_q       <= z_d;
         z_valid_q <= z_valid_d;
         z_sel_q   <= z_sel_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign z       = z_q;
   assign z_valid = z_valid_q;
   assign z_sel   = z_sel_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Testbench for mux_scan_reg: three instances (N=4/HOLD=1, N=3/HOLD=1,
// N=4/HOLD=2) share one stimulus stream and are compared every cycle
// against a behavioural model, plus directed vectors and sequences.
module tb_mux_scan_reg;

   localparam int NI = 3;
   localparam int NS [NI] = '{4, 3, 4};
   localparam int HS [NI] = '{1, 1, 2};

   logic        clk = 1'b0;
   logic        rst, mode, en;
   logic [31:0] d;
   logic [3:0]  d_valid;
   logic [1:0]  sel;

   logic [7:0]  oz  [NI];
   logic        ozv [NI];
   logic [1:0]  ozs [NI];

   int checks = 0;
   int errors = 0;

   // Model state per instance
   int   m_ptr [NI];
   int   m_cnt [NI];
   int   m_z   [NI];
   int   m_zv  [NI];
   int   m_zs  [NI];

   always #5 clk = ~clk;

   mux_scan_reg #(.WIDTH(8), .N(4), .HOLD(1)) u_dut0 (
      .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sel(sel),
      .mode(mode), .en(en), .z(oz[0]), .z_valid(ozv[0]), .z_sel(ozs[0]));

   mux_scan_reg #(.WIDTH(8), .N(3), .HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .d(d[23:0]), .d_valid(d_valid[2:0]), .sel(sel),
      .mode(mode), .en(en), .z(oz[1]), .z_valid(ozv[1]), .z_sel(ozs[1]));

   mux_scan_reg #(.WIDTH(8), .N(4), .HOLD(2)) u_dut2 (
      .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sel(sel),
      .mode(mode), .en(en), .z(oz[2]), .z_valid(ozv[2]), .z_sel(ozs[2]));

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int chan(input int c);
      logic [31:0] dd;
      dd = d;
      return int'(dd[c*8 +: 8]);
   endfunction

   // Behavioural reference: one clock edge for instance k
   function automatic void model_step(input int k);
      int n, h, nxt;
      bit hit;
      n = NS[k];
      h = HS[k];
      if (rst) begin
         m_ptr[k] = 0; m_cnt[k] = 0; m_z[k] = 0; m_zv[k] = 0; m_zs[k] = 0;
      end else if (en) begin
         if (!mode) begin
            m_zs[k]  = int'(sel);
            m_cnt[k] = 0;
            if (int'(sel) < n) begin
               m_z[k]   = chan(int'(sel));
               m_zv[k]  = int'(d_valid[sel]);
               m_ptr[k] = int'(sel);
            end else begin
               m_z[k]  = 0;
               m_zv[k] = 0;
            end
         end else begin
            m_z[k]  = chan(m_ptr[k]);
            m_zv[k] = int'(d_valid[m_ptr[k]]);
            m_zs[k] = m_ptr[k];
            if (m_zv[k] == 0 || m_cnt[k] == h - 1) begin
               nxt = (m_ptr[k] + 1) % n;
               hit = 1'b0;
               for (int s = 1; s <= n; s++) begin
                  if (!hit && d_valid[(m_ptr[k] + s) % n]) begin
                     hit = 1'b1;
                     nxt = (m_ptr[k] + s) % n;
                  end
               end
               m_ptr[k] = nxt;
               m_cnt[k] = 0;
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
      end
   endfunction

   // One clock: sample, advance model, compare all instances
   task automatic step();
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_step(k);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("model_z[%0d]", k),  int'(oz[k]),  m_z[k]);
         chk($sformatf("model_zv[%0d]", k), int'(ozv[k]), m_zv[k]);
         chk($sformatf("model_zs[%0d]", k), int'(ozs[k]), m_zs[k]);
      end
   endtask

   typedef struct {
      int          inst;
      logic [31:0] d;
      logic [3:0]  dv;
      logic [1:0]  sel;
      logic [7:0]  ez;
      logic        ezv;
      logic [1:0]  ezs;
   } vec_t;

   vec_t vecs [7];
   int   exp4 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

   initial begin
      vecs[0] = '{0, 32'hDDCCBBAA, 4'b1011, 2'd2, 8'hCC, 1'b0, 2'd2};
      vecs[1] = '{0, 32'hDDCCBBAA, 4'b1011, 2'd3, 8'hDD, 1'b1, 2'd3};
      vecs[2] = '{0, 32'hDDCCBBAA, 4'b1011, 2'd0, 8'hAA, 1'b1, 2'd0};
      vecs[3] = '{0, 32'hDDCCBBAA, 4'b1011, 2'd1, 8'hBB, 1'b1, 2'd1};
      vecs[4] = '{1, 32'hDDCCBBAA, 4'b1011, 2'd3, 8'h00, 1'b0, 2'd3};
      vecs[5] = '{1, 32'h11223344, 4'b0111, 2'd2, 8'h22, 1'b1, 2'd2};
      vecs[6] = '{2, 32'hDDCCBBAA, 4'b1011, 2'd1, 8'hBB, 1'b1, 2'd1};

      for (int k = 0; k < NI; k++) begin
         m_ptr[k] = 0; m_cnt[k] = 0; m_z[k] = 0; m_zv[k] = 0; m_zs[k] = 0;
      end

      // 1. Reset and enable-low hold
      rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd1; d_valid = 4'hF;
      for (int i = 0; i < 2; i++) begin
         d = $urandom;
         step();
         chk("rst_z", int'(oz[0]), 0);
         chk("rst_zv", int'(ozv[0]), 0);
         chk("rst_zs", int'(ozs[0]), 0);
      end
      rst = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d = $urandom; sel = 2'($urandom); d_valid = 4'($urandom);
         step();
         chk("hold_z", int'(oz[0]), 0);
         chk("hold_zv", int'(ozv[0]), 0);
         chk("hold_zs", int'(ozs[0]), 0);
      end

      // 2/3. Manual select vectors, including out-of-range on N=3
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 7; i++) begin
         d = vecs[i].d; d_valid = vecs[i].dv; sel = vecs[i].sel;
         step();
         chk($sformatf("vec%0d_z", i),  int'(oz[vecs[i].inst]),  int'(vecs[i].ez));
         chk($sformatf("vec%0d_zv", i), int'(ozv[vecs[i].inst]), int'(vecs[i].ezv));
         chk($sformatf("vec%0d_zs", i), int'(ozs[vecs[i].inst]), int'(vecs[i].ezs));
      end

      // 4. HOLD=2 auto scan, all valid
      rst = 1'b1; step(); rst = 1'b0;
      mode = 1'b1; d_valid = 4'hF; d = 32'h44332211;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("hold2_zs%0d", i), int'(ozs[2]), exp4[i]);
      end

      // 5. Skip invalid, stall with en=0, all invalid
      rst = 1'b1; step(); rst = 1'b0;
      d_valid = 4'b0101;
      step(); chk("skip_zs0", int'(ozs[0]), 0); chk("skip_zv0", int'(ozv[0]), 1);
      step(); chk("skip_zs1", int'(ozs[0]), 2); chk("skip_zv1", int'(ozv[0]), 1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         step(); chk("stall_zs", int'(ozs[0]), 2); chk("stall_zv", int'(ozv[0]), 1);
      end
      en = 1'b1;
      step(); chk("skip_zs2", int'(ozs[0]), 0); chk("skip_zv2", int'(ozv[0]), 1);
      step(); chk("skip_zs3", int'(ozs[0]), 2); chk("skip_zv3", int'(ozv[0]), 1);
      rst = 1'b1; step(); rst = 1'b0;
      d_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("none_zs%0d", i), int'(ozs[0]), i);
         chk($sformatf("none_zv%0d", i), int'(ozv[0]), 0);
      end

      // 6. Manual -> auto switch, then reset mid-scan
      mode = 1'b0; sel = 2'd1; d_valid = 4'hF;
      step(); chk("sw_manual_zs", int'(ozs[0]), 1);
      mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("sw_auto_zs%0d", i), int'(ozs[0]), (i + 1) % 4);
      end
      step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("midrst_z", int'(oz[0]), 0);
      chk("midrst_zv", int'(ozv[0]), 0);
      chk("midrst_zs", int'(ozs[0]), 0);
      step(); chk("restart_zs0", int'(ozs[0]), 0);
      step(); chk("restart_zs1", int'(ozs[0]), 1);

      // Randomised run against the model
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 99) < 2);
         en      = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 10) mode = ~mode;
         sel     = 2'($urandom);
         d       = $urandom;
         d_valid = 4'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; generalises the 2:1 single-bit mux to many channels and wide data.
- Adds a registered output, a clock enable, and an auto-scan mode that steps through channels round-robin and skips channels whose data is not valid.
- Used wherever several data sources share one downstream consumer, either under explicit select or under time-multiplexed scan.

Parameters:
- WIDTH, 8, data width per channel, >= 1.
- N, 4, number of channels, >= 2.
- HOLD, 1, enabled cycles spent on a valid channel before auto-scan advances, >= 1.
- SELW, $clog2(N), select and pointer width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- d  input  N*WIDTH  channel data, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- d_valid  input  N  per-channel valid flag.
- sel  input  SELW  manual channel select; used only when mode=0.
- mode  input  1  0 = manual select, 1 = auto-scan.
- en  input  1  clock enable; all state holds when 0.
- z  output  WIDTH  registered selected data.
- z_valid  output  1  registered valid of the selected channel.
- z_sel  output  SELW  registered index of the channel driving z.

Behaviour:
- Internal state:
  - ptr, SELW bits: current scan channel.
  - cnt: hold counter, counts 0..HOLD-1.
- Reset (rst=1 at clock edge; overrides en and mode): z=0, z_valid=0, z_sel=0, ptr=0, cnt=0.
- en=0: z, z_valid, z_sel, ptr and cnt all hold. Input changes are ignored.
- Latency: 1 cycle. Values sampled at edge k appear on the outputs after edge k.
- Manual mode (mode=0, en=1):
  - sel < N: z <= d[sel], z_valid <= d_valid[sel], z_sel <= sel.
  - sel >= N (possible when N is not a power of 2): z <= 0, z_valid <= 0, z_sel <= sel.
  - Pointer tracking: ptr <= sel when sel < N, otherwise ptr holds. cnt <= 0.
- Auto mode (mode=1, en=1):
  - Output update: z <= d[ptr], z_valid <= d_valid[ptr], z_sel <= ptr.
  - Advance when d_valid[ptr]=0 or cnt=HOLD-1.
  - On advance: ptr <= first index j with d_valid[j]=1, searching cyclically ptr+1, ptr+2, ..., ptr+N-1, then ptr itself. If no channel is valid, ptr <= (ptr+1) mod N. cnt <= 0.
  - Otherwise cnt <= cnt+1 and ptr holds.
  - Wrap-around: N-1 is followed by 0.
  - HOLD=1: a single valid channel is re-selected every cycle; multiple valid channels rotate every cycle.
- Mode switch:
  - manual->auto: scan starts from the last valid manual sel, with cnt=0.
  - auto->manual: takes effect on the same edge at which mode=0 is sampled.
- d_valid changes while a channel is being held: a channel that drops valid is output that cycle with z_valid=0, then the pointer advances on the same edge.
- Outputs are pure registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset/hold: rst=1 for 2 cycles with arbitrary d -> z=0, z_valid=0, z_sel=0. Then en=0 with changing d -> outputs stay 0.
2. Manual select: N=4, WIDTH=8, d={8'hDD,8'hCC,8'hBB,8'hAA}, d_valid=4'b1011, sel=2 -> next cycle z=8'hCC, z_valid=0, z_sel=2. sel=3 -> z=8'hDD, z_valid=1.
3. Out of range: N=3, sel=3 -> z=0, z_valid=0, z_sel=3.
4. Auto scan with hold: HOLD=2, all valid, mode=1 from reset -> z_sel sequence 0,0,1,1,2,2,3,3,0,0.
5. Skip invalid and stall:
   - HOLD=1, d_valid=4'b0101 -> z_sel sequence 0,2,0,2 with z_valid=1 throughout.
   - Deassert en for 3 cycles mid-scan -> outputs frozen, sequence resumes unchanged.
   - d_valid=0 -> z_sel steps 0,1,2,3 with z_valid=0.
6. Mode switch/reset mid-scan: manual sel=1, then mode=1 with HOLD=1 and all valid -> z_sel 1,2,3,0. Assert rst mid-sequence -> next cycle z=0, z_valid=0, z_sel=0, and scan restarts at 0.
